// File: rtl/updi_arb_pkg.sv
// Shared types and helpers for the UPDI character-generator arbiter.
package updi_arb_pkg;

  localparam int unsigned BEAT_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    CNT,
    DATA,
    WAIT_DONE
  } state_t;

  // Payload beats that follow a repeat-count byte R: 4*R+1.
  function automatic logic [BEAT_W-1:0] beats(input logic [7:0] r);
    return {r, 2'b01};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  // Distance from ptr is unique per index, so the minimum-distance requester wins.
  always_comb begin
    int unsigned best;
    int unsigned d;
    best  = N_REQ;
    d     = 0;
    grant = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      d = (j + N_REQ - 32'(ptr)) % N_REQ;
      if (req[j] && (d < best)) best = d;
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      d        = (j + N_REQ - 32'(ptr)) % N_REQ;
      grant[j] = req[j] && (d == best);
    end
  end

endmodule

// File: rtl/updi_cg_arbiter.sv
// Round-robin arbiter sharing the UPDI character generator between byte-stream requesters.
// Optional watchdog abort is enabled by defining UPDI_ARB_TIMEOUT_EN.
module updi_cg_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  output logic               o_abort,
  output logic               o_cg_write,
  output logic               o_cg_valid,
  output logic [7:0]         o_cg_data,
  input  logic               i_cg_ready,
  input  logic               i_cg_trans_en
);
  import updi_arb_pkg::*;

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if ((N_REQ < 2) || (N_REQ > 8) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("updi_cg_arbiter: unsupported parameter values");
  end

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d, arb_grant;
  logic [PTR_W-1:0]   ptr_q, ptr_d, gidx, ptr_inc;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               cg_write_q, cg_write_d;
  logic               busy_q, busy_d;
  logic               fwd, sel_valid, xfer;
  logic [7:0]         sel_data;

`ifdef UPDI_ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               abort_q, abort_d;
`endif

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  // Index and byte of the granted requester.
  always_comb begin
    gidx     = '0;
    sel_data = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (grant_q[j]) begin
        gidx     = PTR_W'(j);
        sel_data = i_req_data[8*j +: 8];
      end
    end
  end

  assign ptr_inc   = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);
  assign fwd       = (state_q == CNT) || (state_q == DATA);
  assign sel_valid = |(i_req_valid & grant_q);
  assign xfer      = fwd && sel_valid && i_cg_ready;

  assign o_cg_valid  = fwd && sel_valid;
  assign o_cg_data   = fwd ? sel_data : 8'h00;
  assign o_req_ready = fwd ? (grant_q & {N_REQ{i_cg_ready}}) : '0;
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;
  assign o_cg_write  = cg_write_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_d     = beat_q;
    cg_write_d = 1'b0;
`ifdef UPDI_ARB_TIMEOUT_EN
    tmr_d      = '0;
    abort_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          grant_d    = arb_grant;
          cg_write_d = 1'b1;
          state_d    = GRANT;
        end
      end
      GRANT: state_d = CNT;
      CNT: begin
        if (xfer) begin
          beat_d  = beats(sel_data);
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          beat_d = beat_q - BEAT_W'(1);
          if (beat_q == BEAT_W'(1)) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_cg_trans_en) begin
          grant_d = '0;
          ptr_d   = ptr_inc;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UPDI_ARB_TIMEOUT_EN
    // Stall watchdog: counts cycles since the last beat; normal completion wins.
    if (((state_q == CNT) || (state_q == DATA) || (state_q == WAIT_DONE)) &&
        (state_d != IDLE) && !xfer) begin
      tmr_d = tmr_q + TMR_W'(1);
      if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        abort_d = 1'b1;
        grant_d = '0;
        ptr_d   = ptr_inc;
        state_d = IDLE;
      end
    end
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      beat_q     <= '0;
      cg_write_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_q     <= beat_d;
      cg_write_q <= cg_write_d;
      busy_q     <= busy_d;
    end
  end

`ifdef UPDI_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tmr_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      abort_q <= abort_d;
    end
  end

  assign o_abort = abort_q;
`else
  assign o_abort = 1'b0;
`endif

endmodule
